axis_packet_arbiter: RTL and testbench

Packet-granular round-robin arbiter merging two 256-bit AXI-Stream frame sources onto one output port with the full tuser sideband. It lets frame_gen instances, or a generator plus a live datapath, share a single frame_check or downstream pipeline. It never interleaves beats of different packets. It holds one grant from the first accepted beat through the tlast beat.

---
 rtl/axis_packet_arbiter.sv | 177 +++++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
//
// Packet-granular round-robin arbiter. It merges two AXI-Stream frame sources,
// each with the full tuser sideband, onto one output port. Once an input is
// granted, it owns the output from its first beat through its tlast beat.
// Beats of different packets are never interleaved.
//
// Handshake: a beat moves on any port only when tvalid and tready are both
// high on the same rising clk edge. tready never depends on the same port's
// tvalid. The granted input's tready is m_axis_tready passed straight through.
// The non-granted input always sees tready low.
//
// Ports:
//   clk, axi_reset           clock, asynchronous active-high reset
//   s0_axis_* / s1_axis_*    input streams (tdata, tkeep, tuser_*, tvalid,
//                            tlast in; tready out)
//   m_axis_*                 merged output stream (m_axis_tready in)
//   grant                    input currently or most recently selected
//   busy                     high while forwarding a packet; with only two
//                            FSM states this is the full state for debug
//   pkt_count0/pkt_count1    packets forwarded per input (wrapping 32-bit)
//
// Build option: define AXIS_PACKET_ARBITER_STATS_EN to build the packet
// counters. Without it, both counter ports read 32'h0.
module axis_packet_arbiter #(
  parameter int C_DATA_WIDTH = 256
) (
  input  logic                      clk,
  input  logic                      axi_reset,
  input  logic [C_DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic [13:0]               s0_axis_tuser_packet_length,
  input  logic [2:0]                s0_axis_tuser_in_port,
  input  logic [7:0]                s0_axis_tuser_out_port,
  input  logic [2:0]                s0_axis_tuser_in_vport,
  input  logic [7:0]                s0_axis_tuser_out_vport,
  input  logic                      s0_axis_tvalid,
  input  logic                      s0_axis_tlast,
  output logic                      s0_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic [13:0]               s1_axis_tuser_packet_length,
  input  logic [2:0]                s1_axis_tuser_in_port,
  input  logic [7:0]                s1_axis_tuser_out_port,
  input  logic [2:0]                s1_axis_tuser_in_vport,
  input  logic [7:0]                s1_axis_tuser_out_vport,
  input  logic                      s1_axis_tvalid,
  input  logic                      s1_axis_tlast,
  output logic                      s1_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [13:0]               m_axis_tuser_packet_length,
  output logic [2:0]                m_axis_tuser_in_port,
  output logic [7:0]                m_axis_tuser_out_port,
  output logic [2:0]                m_axis_tuser_in_vport,
  output logic [7:0]                m_axis_tuser_out_vport,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      grant,
  output logic                      busy,
  output logic [31:0]               pkt_count0,
  output logic [31:0]               pkt_count1
);

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;

  always_ff @(posedge clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= IDLE;
      // Reset to 1 so that input 0 wins the first contested arbitration.
      grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d                    = state_q;
    grant_d                    = grant_q;
    s0_axis_tready             = 1'b0;
    s1_axis_tready             = 1'b0;
    m_axis_tdata               = '0;
    m_axis_tkeep               = '0;
    m_axis_tuser_packet_length = '0;
    m_axis_tuser_in_port       = '0;
    m_axis_tuser_out_port      = '0;
    m_axis_tuser_in_vport      = '0;
    m_axis_tuser_out_vport     = '0;
    m_axis_tvalid              = 1'b0;
    m_axis_tlast               = 1'b0;

    case (state_q)
      IDLE: begin
        // One arbitration cycle per packet. When both inputs request, the
        // input that did not go last wins. The chosen input may drop tvalid
        // afterwards; FWD simply waits for it to return.
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          grant_d = (s0_axis_tvalid && s1_axis_tvalid) ? ~grant_q : s1_axis_tvalid;
          state_d = FWD;
        end
      end
      FWD: begin
        if (grant_q) begin
          m_axis_tdata               = s1_axis_tdata;
          m_axis_tkeep               = s1_axis_tkeep;
          m_axis_tuser_packet_length = s1_axis_tuser_packet_length;
          m_axis_tuser_in_port       = s1_axis_tuser_in_port;
          m_axis_tuser_out_port      = s1_axis_tuser_out_port;
          m_axis_tuser_in_vport      = s1_axis_tuser_in_vport;
          m_axis_tuser_out_vport     = s1_axis_tuser_out_vport;
          m_axis_tvalid              = s1_axis_tvalid;
          m_axis_tlast               = s1_axis_tlast;
          s1_axis_tready             = m_axis_tready;
        end else begin
          m_axis_tdata               = s0_axis_tdata;
          m_axis_tkeep               = s0_axis_tkeep;
          m_axis_tuser_packet_length = s0_axis_tuser_packet_length;
          m_axis_tuser_in_port       = s0_axis_tuser_in_port;
          m_axis_tuser_out_port      = s0_axis_tuser_out_port;
          m_axis_tuser_in_vport      = s0_axis_tuser_in_vport;
          m_axis_tuser_out_vport     = s0_axis_tuser_out_vport;
          m_axis_tvalid              = s0_axis_tvalid;
          m_axis_tlast               = s0_axis_tlast;
          s0_axis_tready             = m_axis_tready;
        end
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q == FWD);

`ifdef AXIS_PACKET_ARBITER_STATS_EN
  logic        last_xfer;
  logic [31:0] pkt_count0_q, pkt_count0_d;
  logic [31:0] pkt_count1_q, pkt_count1_d;

  // The tlast transfer can only happen in FWD, because m_axis_tvalid is low in IDLE.
  assign last_xfer = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    pkt_count0_d = pkt_count0_q;
    pkt_count1_d = pkt_count1_q;
    if (last_xfer && !grant_q) pkt_count0_d = pkt_count0_q + 32'd1;
    if (last_xfer &&  grant_q) pkt_count1_d = pkt_count1_q + 32'd1;
  end

  always_ff @(posedge clk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
    end else begin
      pkt_count0_q <= pkt_count0_d;
      pkt_count1_q <= pkt_count1_d;
    end
  end

  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;
`else
  assign pkt_count0 = 32'h0;
  assign pkt_count1 = 32'h0;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [13:0]  len;
    logic [2:0]   in_port;
    logic [7:0]   out_port;
    logic [2:0]   in_vport;
    logic [7:0]   out_vport;
    logic         last;
  } beat_t;

  localparam int BW = $bits(beat_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic axi_reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  beat_t s0_b = '0, s1_b = '0;
  logic  s0_v = 1'b0, s1_v = 1'b0;
  logic  s0_axis_tready, s1_axis_tready;
  logic  m_axis_tready = 1'b0;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [13:0]  m_axis_tuser_packet_length;
  logic [2:0]   m_axis_tuser_in_port, m_axis_tuser_in_vport;
  logic [7:0]   m_axis_tuser_out_port, m_axis_tuser_out_vport;
  logic         m_axis_tvalid, m_axis_tlast, grant, busy;
  logic [31:0]  pkt_count0, pkt_count1;
  beat_t        m_b;

  assign m_b = {m_axis_tdata, m_axis_tkeep, m_axis_tuser_packet_length, m_axis_tuser_in_port,
                m_axis_tuser_out_port, m_axis_tuser_in_vport, m_axis_tuser_out_vport, m_axis_tlast};

  axis_packet_arbiter #(.C_DATA_WIDTH(256)) dut (
    .clk(clk), .axi_reset(axi_reset),
    .s0_axis_tdata(s0_b.data), .s0_axis_tkeep(s0_b.keep),
    .s0_axis_tuser_packet_length(s0_b.len), .s0_axis_tuser_in_port(s0_b.in_port),
    .s0_axis_tuser_out_port(s0_b.out_port), .s0_axis_tuser_in_vport(s0_b.in_vport),
    .s0_axis_tuser_out_vport(s0_b.out_vport), .s0_axis_tvalid(s0_v),
    .s0_axis_tlast(s0_b.last), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_b.data), .s1_axis_tkeep(s1_b.keep),
    .s1_axis_tuser_packet_length(s1_b.len), .s1_axis_tuser_in_port(s1_b.in_port),
    .s1_axis_tuser_out_port(s1_b.out_port), .s1_axis_tuser_in_vport(s1_b.in_vport),
    .s1_axis_tuser_out_vport(s1_b.out_vport), .s1_axis_tvalid(s1_v),
    .s1_axis_tlast(s1_b.last), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser_packet_length(m_axis_tuser_packet_length),
    .m_axis_tuser_in_port(m_axis_tuser_in_port), .m_axis_tuser_out_port(m_axis_tuser_out_port),
    .m_axis_tuser_in_vport(m_axis_tuser_in_vport), .m_axis_tuser_out_vport(m_axis_tuser_out_vport),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant(grant), .busy(busy), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  beat_t        src0_q[$];
  beat_t        src1_q[$];
  logic [255:0] exp_q[$];

  // Packet-level view: owner = -1 between packets (arbitration slot),
  // otherwise the source whose packet currently holds the output.
  int          owner  = -1;
  int          last_g = 1;
  logic [31:0] cnt0 = '0, cnt1 = '0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef AXIS_PACKET_ARBITER_STATS_EN
    return c;
`else
    return 32'h0 & c;
`endif
  endfunction

  task automatic push_pkt(input int src, input int nbeats, input logic [13:0] len,
                          input logic [2:0] inp);
    beat_t b;
    logic [7:0] op, ovp;
    logic [2:0] ivp;
    op  = 8'($urandom());
    ovp = 8'($urandom());
    ivp = 3'($urandom());
    for (int i = 0; i < nbeats; i++) begin
      b.data      = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
      b.keep      = (i == nbeats - 1) ? 32'($urandom()) | 32'h1 : 32'hFFFF_FFFF;
      b.len       = len;
      b.in_port   = inp;
      b.out_port  = op;
      b.in_vport  = ivp;
      b.out_vport = ovp;
      b.last      = (i == nbeats - 1);
      if (src == 0) src0_q.push_back(b);
      else          src1_q.push_back(b);
    end
  endtask

  task automatic reset_model();
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    owner  = -1;
    last_g = 1;
    cnt0   = '0;
    cnt1   = '0;
  endtask

  // One clock cycle: drive the sources at negedge, check all outputs, then
  // advance the model to the state expected after the next rising edge.
  task automatic step(input bit en0, input bit en1, input bit mr, input bit rst_mid);
    beat_t eb;
    bit    ev, er0, er1, ebusy, eg;
    @(negedge clk);
    s0_v          = en0 && (src0_q.size() > 0);
    s1_v          = en1 && (src1_q.size() > 0);
    s0_b          = (src0_q.size() > 0) ? src0_q[0] : '0;
    s1_b          = (src1_q.size() > 0) ? src1_q[0] : '0;
    m_axis_tready = mr;
    #1;
    eb = '0; ev = 0; er0 = 0; er1 = 0; ebusy = 0; eg = last_g[0];
    if (owner == 0) begin
      eb = s0_b; ev = s0_v; er0 = mr; ebusy = 1; eg = 0;
    end else if (owner == 1) begin
      eb = s1_b; ev = s1_v; er1 = mr; ebusy = 1; eg = 1;
    end
    check("m_beat",   BW'(m_b), BW'(eb));
    check("m_tvalid", BW'(m_axis_tvalid), BW'(ev));
    check("s0_tready", BW'(s0_axis_tready), BW'(er0));
    check("s1_tready", BW'(s1_axis_tready), BW'(er1));
    check("busy",     BW'(busy), BW'(ebusy));
    check("grant",    BW'(grant), BW'(eg));
    check("pkt_count0", BW'(pkt_count0), BW'(exp_cnt(cnt0)));
    check("pkt_count1", BW'(pkt_count1), BW'(exp_cnt(cnt1)));

    if (rst_mid) begin
      // Asynchronous reset in the middle of a packet: outputs drop at once.
      axi_reset = 1'b1;
      #1;
      check("rst_m_tvalid", BW'(m_axis_tvalid), BW'(0));
      check("rst_s0_tready", BW'(s0_axis_tready), BW'(0));
      check("rst_s1_tready", BW'(s1_axis_tready), BW'(0));
      check("rst_busy",  BW'(busy), BW'(0));
      check("rst_grant", BW'(grant), BW'(1));
      check("rst_cnt0",  BW'(pkt_count0), BW'(0));
      check("rst_cnt1",  BW'(pkt_count1), BW'(0));
      reset_model();
      s0_v = 1'b0;
      s1_v = 1'b0;
      return;
    end

    // Model advance.
    if (ev && mr) begin
      exp_q.push_back(eb.data);
      if (owner == 0) void'(src0_q.pop_front());
      else            void'(src1_q.pop_front());
      if (eb.last) begin
        if (owner == 0) cnt0 = cnt0 + 32'd1;
        else            cnt1 = cnt1 + 32'd1;
        owner = -1;
      end
    end else if (owner < 0 && (s0_v || s1_v)) begin
      owner  = (s0_v && s1_v) ? 1 - last_g : (s1_v ? 1 : 0);
      last_g = owner;
    end

    // Monitor side of the scoreboard: every observed output transfer must
    // match the next expected beat.
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      if (exp_q.size() == 0) check("sb_extra_beat", BW'(1), BW'(0));
      else                   check("sb_data", BW'(m_axis_tdata), BW'(exp_q.pop_front()));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_tvalid", BW'(m_axis_tvalid), BW'(0));
    check("reset_tready0", BW'(s0_axis_tready), BW'(0));
    check("reset_tready1", BW'(s1_axis_tready), BW'(0));
    check("reset_grant", BW'(grant), BW'(1));
    check("reset_busy", BW'(busy), BW'(0));
    check("reset_cnt0", BW'(pkt_count0), BW'(0));
    check("reset_cnt1", BW'(pkt_count1), BW'(0));
    axi_reset = 1'b0;

    // Input 0 alone: 3-beat packet, length 96, in_port 2.
    push_pkt(0, 3, 14'd96, 3'd2);
    repeat (6) step(1, 0, 1, 0);
    check("t1_grant", BW'(grant), BW'(0));

    // Both inputs continuously valid with 1-beat packets: alternating order.
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 1, 14'd32, 3'd0);
      push_pkt(1, 1, 14'd32, 3'd1);
    end
    repeat (18) step(1, 1, 1, 0);

    // Input 1 sends 4 beats; input 0 raises tvalid on beat 2 and must wait.
    push_pkt(1, 4, 14'd128, 3'd5);
    push_pkt(0, 1, 14'd20, 3'd3);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    repeat (7) step(1, 1, 1, 0);

    // Downstream ready 1,0,0,1 during a 2-beat packet.
    push_pkt(0, 2, 14'd64, 3'd1);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);

    // Reset during beat 2 of a 5-beat packet.
    push_pkt(1, 5, 14'd160, 3'd4);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    @(negedge clk);
    axi_reset = 1'b0;
    push_pkt(0, 1, 14'd8, 3'd0);
    push_pkt(1, 1, 14'd8, 3'd1);
    repeat (6) step(1, 1, 1, 0);

    // Randomised traffic with stalls and mid-packet tvalid gaps.
    for (int c = 0; c < 1500; c++) begin
      if (src0_q.size() < 2) push_pkt(0, $urandom_range(1, 4), 14'($urandom()), 3'($urandom()));
      if (src1_q.size() < 2) push_pkt(1, $urandom_range(1, 4), 14'($urandom()), 3'($urandom()));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0);
    end
    // Drain everything still queued (bounded).
    for (int c = 0; c < 60; c++) step(1, 1, 1, 0);
    check("src_drained", BW'(src0_q.size() + src1_q.size()), BW'(0));

`ifdef AXIS_PACKET_ARBITER_STATS_EN
    // Counter wrap: preload input 0's counter to all ones while idle.
    @(negedge clk);
    dut.pkt_count0_q = 32'hFFFF_FFFF;
    cnt0 = 32'hFFFF_FFFF;
    push_pkt(0, 1, 14'd4, 3'd0);
    repeat (4) step(1, 0, 1, 0);
    check("cnt0_wrap", BW'(pkt_count0), BW'(32'h0));
`endif

    check("sb_drain", BW'(exp_q.size()), BW'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
